// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared types and constants for the register-bank writeback arbiter.
// Holds the data/register sizes, the writeback request record and the grant encoding.
package regbank_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] regaddr_t;

  typedef struct packed {
    logic            valid;
    regaddr_t        rdaddr;
    logic [XLEN-1:0] rddata;
  } wb_req_t;

  // Round-robin pointer values: which side wins when both request
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/regbank_wb_arbiter_if.sv
// Writeback request channel from one execution unit into the arbiter.
// The requester holds valid and payload steady until ready is seen high at a clock edge.
interface regbank_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);

  logic            valid;
  logic            ready;
  logic [AW-1:0]   rdaddr;
  logic [XLEN-1:0] rddata;

  modport master (
    output valid,
    output rdaddr,
    output rddata,
    input  ready
  );

  modport slave (
    input  valid,
    input  rdaddr,
    input  rddata,
    output ready
  );

endinterface

// File: rtl/regbank_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on reservation
// and cleared on commit, with two combinational query ports for hazard detection.
module regbank_scoreboard #(
  parameter int NREGS = regbank_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_setEn,
  input  logic [AW-1:0]    i_setAddr,
  input  logic             i_clrEn,
  input  logic [AW-1:0]    i_clrAddr,
  input  logic [AW-1:0]    i_rs1Addr,
  input  logic [AW-1:0]    i_rs2Addr,
  output logic             o_rs1Busy,
  output logic             o_rs2Busy,
  output logic [NREGS-1:0] o_busyVec
);

  logic [NREGS-1:0] r_busy;

  // The set is applied after the clear so a same-cycle reservation by a newer instruction wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (i_clrEn) begin
        r_busy[i_clrAddr] <= 1'b0;
      end
      if (i_setEn && (i_setAddr != '0)) begin
        r_busy[i_setAddr] <= 1'b1;
      end
    end
  end

  assign o_rs1Busy = r_busy[i_rs1Addr] && (i_rs1Addr != '0);
  assign o_rs2Busy = r_busy[i_rs2Addr] && (i_rs2Addr != '0);
  assign o_busyVec = r_busy;

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Round-robin writeback arbiter for the register bank's single write port (ALU = A, LSU = B).
// Define REGBANK_WB_BYPASS_EN to add commit-cycle forwarding outputs that also suppress the stall.
module regbank_wb_arbiter #(
  parameter int XLEN  = regbank_pkg::XLEN,
  parameter int NREGS = regbank_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  regbank_wb_arbiter_if.slave a_wb,
  regbank_wb_arbiter_if.slave b_wb,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    rs1addr,
  input  logic [AW-1:0]    rs2addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             regwrite,
  output logic [AW-1:0]    rdaddr,
  output logic [XLEN-1:0]  rddata,
  output logic [NREGS-1:0] busy_vec
`ifdef REGBANK_WB_BYPASS_EN
  ,
  output logic             fwd1_valid,
  output logic [XLEN-1:0]  fwd1_data,
  output logic             fwd2_valid,
  output logic [XLEN-1:0]  fwd2_data
`endif
);

  logic            r_rrPtr;
  logic            r_regwrite;
  logic [AW-1:0]   r_rdaddr;
  logic [XLEN-1:0] r_rddata;

  logic w_grantA;
  logic w_grantB;
  logic w_sbBusy1;
  logic w_sbBusy2;

  // A lone requester always wins; on contention the pointer decides. Nothing is granted in reset.
  assign w_grantA = rst_n && a_wb.valid && (!b_wb.valid || (r_rrPtr == regbank_pkg::GNT_A));
  assign w_grantB = rst_n && b_wb.valid && (!a_wb.valid || (r_rrPtr == regbank_pkg::GNT_B));

  assign a_wb.ready = w_grantA;
  assign b_wb.ready = w_grantB;

  // Writes to x0 complete the handshake but never reach the bank, so the write port keeps its last address/data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rrPtr    <= regbank_pkg::GNT_A;
      r_regwrite <= 1'b0;
      r_rdaddr   <= '0;
      r_rddata   <= '0;
    end else if (w_grantA) begin
      r_rrPtr    <= regbank_pkg::GNT_B;
      r_regwrite <= (a_wb.rdaddr != '0);
      if (a_wb.rdaddr != '0) begin
        r_rdaddr <= a_wb.rdaddr;
        r_rddata <= a_wb.rddata;
      end
    end else if (w_grantB) begin
      r_rrPtr    <= regbank_pkg::GNT_A;
      r_regwrite <= (b_wb.rdaddr != '0);
      if (b_wb.rdaddr != '0) begin
        r_rdaddr <= b_wb.rdaddr;
        r_rddata <= b_wb.rddata;
      end
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  assign regwrite = r_regwrite;
  assign rdaddr   = r_rdaddr;
  assign rddata   = r_rddata;

  regbank_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_setEn   (rsv_valid),
    .i_setAddr (rsv_addr),
    .i_clrEn   (r_regwrite),
    .i_clrAddr (r_rdaddr),
    .i_rs1Addr (rs1addr),
    .i_rs2Addr (rs2addr),
    .o_rs1Busy (w_sbBusy1),
    .o_rs2Busy (w_sbBusy2),
    .o_busyVec (busy_vec)
  );

`ifdef REGBANK_WB_BYPASS_EN
  // The value being committed this cycle can be forwarded, so the reader need not wait for the bank
  assign fwd1_valid = r_regwrite && (r_rdaddr != '0) && (r_rdaddr == rs1addr);
  assign fwd2_valid = r_regwrite && (r_rdaddr != '0) && (r_rdaddr == rs2addr);
  assign fwd1_data  = r_rddata;
  assign fwd2_data  = r_rddata;
  assign rs1_busy   = w_sbBusy1 && !fwd1_valid;
  assign rs2_busy   = w_sbBusy2 && !fwd2_valid;
`else
  assign rs1_busy = w_sbBusy1;
  assign rs2_busy = w_sbBusy2;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: expected bank writes are queued as stimulus is issued
// and a negedge monitor compares each commit; handshake and scoreboard state are checked inline.
module tb_regbank_wb_arbiter;
  import regbank_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rsv_valid = 1'b0;
  regaddr_t    rsv_addr = '0;
  regaddr_t    rs1addr = '0;
  regaddr_t    rs2addr = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        regwrite;
  regaddr_t    rdaddr;
  logic [31:0] rddata;
  logic [31:0] busy_vec;
`ifdef REGBANK_WB_BYPASS_EN
  logic        fwd1_valid;
  logic [31:0] fwd1_data;
  logic        fwd2_valid;
  logic [31:0] fwd2_data;
`endif

  regbank_wb_arbiter_if #(.XLEN(32), .AW(5)) aIf ();
  regbank_wb_arbiter_if #(.XLEN(32), .AW(5)) bIf ();

  regbank_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_wb       (aIf.slave),
    .b_wb       (bIf.slave),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .rs1addr    (rs1addr),
    .rs2addr    (rs2addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .regwrite   (regwrite),
    .rdaddr     (rdaddr),
    .rddata     (rddata),
    .busy_vec   (busy_vec)
`ifdef REGBANK_WB_BYPASS_EN
    ,
    .fwd1_valid (fwd1_valid),
    .fwd1_data  (fwd1_data),
    .fwd2_valid (fwd2_valid),
    .fwd2_data  (fwd2_data)
`endif
  );

  always #5 clk = ~clk;

  int      vecCount = 0;
  int      missCount = 0;
  wb_req_t expQ[$];
  wb_req_t monExp;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle's inputs on the falling edge and settles before the next rising edge
  task automatic applyStimulus(input logic aV, input regaddr_t aAddr, input logic [31:0] aData,
                               input logic bV, input regaddr_t bAddr, input logic [31:0] bData,
                               input logic rV, input regaddr_t rAddr);
    @(negedge clk);
    aIf.valid  = aV;
    aIf.rdaddr = aAddr;
    aIf.rddata = aData;
    bIf.valid  = bV;
    bIf.rdaddr = bAddr;
    bIf.rddata = bData;
    rsv_valid  = rV;
    rsv_addr   = rAddr;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic expectCommit(input regaddr_t addr, input logic [31:0] data);
    expQ.push_back('{valid: 1'b1, rdaddr: addr, rddata: data});
  endtask

  // Every bank write seen outside reset must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && regwrite === 1'b1) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL unexpectedCommit: got rdaddr=%0d rddata=%0h, expected no write", rdaddr, rddata);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("commit", {27'b0, rdaddr, rddata}, {27'b0, monExp.rdaddr, monExp.rddata});
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aIf.valid = 1'b0; aIf.rdaddr = '0; aIf.rddata = '0;
    bIf.valid = 1'b0; bIf.rdaddr = '0; bIf.rddata = '0;

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0);
    checkOutput("aReadyInReset", aIf.ready, 0);
    checkOutput("bReadyInReset", bIf.ready, 0);
    idle();
    checkOutput("regwriteReset", regwrite, 0);
    checkOutput("busyVecReset", busy_vec, 0);
    checkOutput("rdaddrReset", rdaddr, 0);
    rst_n = 1'b1;
    idle();
    checkOutput("busyVecIdle", busy_vec, 0);

    $display("[TB] single write to x5");
    rs1addr = 5'd5;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("rs1BusyReserved", rs1_busy, 1);
    checkOutput("busyVecX5", busy_vec, 32'h0000_0020);
    checkOutput("aReadySingle", aIf.ready, 1);
    checkOutput("bReadySingle", bIf.ready, 0);
    expectCommit(5'd5, 32'hDEADBEEF);
    idle();
    checkOutput("regwriteCommit", regwrite, 1);
`ifdef REGBANK_WB_BYPASS_EN
    checkOutput("rs1BusyForwarded", rs1_busy, 0);
    checkOutput("fwd1Data", fwd1_data, 32'hDEADBEEF);
`else
    checkOutput("rs1BusyDuringCommit", rs1_busy, 1);
`endif
    idle();
    checkOutput("rs1BusyCleared", rs1_busy, 0);
    checkOutput("busyVecClearedX5", busy_vec, 0);
    checkOutput("regwriteDropped", regwrite, 0);
    checkOutput("rdaddrHeld", rdaddr, 5);

    $display("[TB] lone B write to unreserved x9");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    checkOutput("bReadyLone", bIf.ready, 1);
    expectCommit(5'd9, 32'h99);

    $display("[TB] contention: expect A, B, A, B");
    begin
      logic [31:0] aData;
      logic [31:0] bData;
      aData = 32'h1000;
      bData = 32'h2000;
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, 5'd1, aData, 1'b1, 5'd2, bData, 1'b0, 5'd0);
        checkOutput("aReadyContend", aIf.ready, (i % 2 == 0) ? 1 : 0);
        checkOutput("bReadyContend", bIf.ready, (i % 2 == 0) ? 0 : 1);
        if (i % 2 == 0) begin
          expectCommit(5'd1, aData);
          aData = aData + 1;
        end else begin
          expectCommit(5'd2, bData);
          bData = bData + 1;
        end
      end
    end
    idle();
    idle();

    $display("[TB] simultaneous set and clear on x7");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("aReadyX7", aIf.ready, 1);
    expectCommit(5'd7, 32'h77);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    idle();
    checkOutput("busyVecSetWins", busy_vec, 32'h0000_0080);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h777, 1'b0, 5'd0);
    expectCommit(5'd7, 32'h777);
    idle();
    idle();
    checkOutput("busyVecX7Cleared", busy_vec, 0);

    $display("[TB] x0 reservation and writeback");
    rs1addr = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    checkOutput("busyVecX0Rsv", busy_vec, 0);
    checkOutput("bReadyX0", bIf.ready, 1);
    idle();
    checkOutput("regwriteX0", regwrite, 0);
    checkOutput("busyVecX0", busy_vec, 0);
    checkOutput("rs1BusyX0", rs1_busy, 0);

    $display("[TB] reset while a B write is in flight");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hCAFE, 1'b0, 5'd0);
    checkOutput("bReadyFlight", bIf.ready, 1);
    checkOutput("busyVecX4", busy_vec, 32'h0000_0010);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bIf.valid = 1'b0;
    @(negedge clk);
    idle();
    checkOutput("regwriteAfterReset", regwrite, 0);
    checkOutput("busyVecAfterReset", busy_vec, 0);
    checkOutput("rddataAfterReset", rddata, 0);
    rst_n = 1'b1;

    $display("[TB] reset returns priority to A");
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectCommit(5'd8, 32'h88);
    idle();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0);
    checkOutput("aReadyAfterReset", aIf.ready, 1);
    checkOutput("bReadyAfterReset", bIf.ready, 0);
    expectCommit(5'd10, 32'hA0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0);
    checkOutput("bReadySecond", bIf.ready, 1);
    expectCommit(5'd11, 32'hB0);
    idle();

`ifdef REGBANK_WB_BYPASS_EN
    $display("[TB] forwarding on x3");
    rs2addr = 5'd3;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    applyStimulus(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("rs2BusyBeforeCommit", rs2_busy, 1);
    expectCommit(5'd3, 32'h55);
    idle();
    checkOutput("fwd2Valid", fwd2_valid, 1);
    checkOutput("fwd2Data", fwd2_data, 32'h55);
    checkOutput("rs2BusyForwarded", rs2_busy, 0);
    idle();
    checkOutput("fwd2ValidDropped", fwd2_valid, 0);
`endif

    idle();
    idle();
    checkOutput("queueDrained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
- Shares the register bank's single write port between two writeback requesters: ALU (port A) and load/store unit (port B).
- Arbitrates round-robin and drives a registered write request (regwrite/rdaddr/rddata) into the register bank.
- Holds a 32-entry pending-write scoreboard so the issue stage can stall on RAW hazards against rs1/rs2.

Parameters:
- XLEN, 32, data width of writeback and register bank data.
- NREGS, 32, number of architectural registers; address width is clog2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- a_valid  input  1  ALU writeback request.
- a_ready  output  1  ALU request accepted this cycle.
- a_rdaddr  input  5  ALU destination register.
- a_rddata  input  XLEN  ALU result.
- b_valid  input  1  LSU writeback request.
- b_ready  output  1  LSU request accepted this cycle.
- b_rdaddr  input  5  LSU destination register.
- b_rddata  input  XLEN  LSU load data.
- rsv_valid  input  1  issue stage reserves a destination register.
- rsv_addr  input  5  register being reserved.
- rs1addr  input  5  hazard query address 1.
- rs2addr  input  5  hazard query address 2.
- rs1_busy  output  1  rs1addr has a pending write.
- rs2_busy  output  1  rs2addr has a pending write.
- regwrite  output  1  write enable to the register bank.
- rdaddr  output  5  write address to the register bank.
- rddata  output  XLEN  write data to the register bank.
- busy_vec  output  NREGS  full scoreboard, for debug.

Behaviour:
- Reset (rst_n=0 at edge):
  - regwrite=0, rdaddr=0, rddata=0, busy_vec=0.
  - rr_ptr=0, so A has priority first.
  - a_ready=0 and b_ready=0 whenever rst_n=0.
  - Reset mid-operation drops any in-flight request without a commit.
- Handshake:
  - A transfer occurs when valid&ready are high at the edge.
  - ready is combinational from both valids and rr_ptr; requesters must hold payload until ready.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: grant the side rr_ptr selects (0=A, 1=B).
  - After any grant, rr_ptr points to the non-granted side.
- Output stage (always drains, never stalls):
  - On a grant, next cycle regwrite=1 with the granted rdaddr/rddata; otherwise regwrite=0 and rdaddr/rddata hold.
  - Latency: request accepted at edge N, bank written at edge N+1, data readable from the bank after N+1.
  - Grant with rdaddr=0: handshake completes, regwrite stays 0, scoreboard untouched.
- Scoreboard:
  - rsv_valid with rsv_addr!=0 sets busy[rsv_addr] at the edge. Reserving x0 is ignored.
  - regwrite=1 at an edge clears busy[rdaddr] at that edge.
  - Simultaneous set and clear of the same register: set wins (the newer instruction owns it).
  - Reserving an already-busy register leaves it busy. No counting; the issue stage guarantees no WAW.
  - rs1_busy = busy[rs1addr], rs2_busy = busy[rs2addr], combinational. Register 0 always reports 0.
- A writeback to a non-busy register is legal; the write happens and the clear is a no-op.

Optional Feature:
- Macro: REGBANK_WB_BYPASS_EN.
- With the macro:
  - Adds outputs fwd1_valid/fwd1_data and fwd2_valid/fwd2_data.
  - fwdN_valid=1 when regwrite=1, rdaddr!=0 and rdaddr==rsNaddr; fwdN_data=rddata.
  - rsN_busy is forced 0 when fwdN_valid=1, saving one stall cycle.
- Without the macro: the fwd ports do not exist and busy follows the scoreboard only.

Decomposition:
- Shared package regbank_pkg:
  - XLEN and NREGS constants.
  - regaddr_t (5-bit) type.
  - wb_req_t struct {valid, rdaddr, rddata}.
  - Grant encoding constants GNT_A=0, GNT_B=1.
- One natural sub-module: regbank_scoreboard, holding the busy vector, set/clear logic and the query read ports.
- The arbiter and output register stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 two cycles, then 1 → regwrite=0, busy_vec=0, a_ready=b_ready=0 during reset.
- Single write: rsv x5; then a_valid, a_rdaddr=5, a_rddata=0xDEADBEEF → a_ready=1 same cycle; next cycle regwrite=1, rdaddr=5, rddata=0xDEADBEEF; busy[5] clears after that edge; rs1addr=5 gives rs1_busy 1→0.
- Contention: a_valid and b_valid held 4 cycles (A→x1, B→x2, new data each grant) → grants A, B, A, B; regwrite commits alternate x1/x2.
- Simultaneous set/clear: busy[7]=1, commit to x7 in the same cycle as rsv_addr=7 → busy[7] stays 1.
- x0: rsv_addr=0, then b_valid with b_rdaddr=0, data 0x1234 → b_ready=1, regwrite stays 0, busy_vec=0, rs1_busy(0)=0.
- Reset mid-flight: b granted at edge N, rst_n=0 at edge N+1 → regwrite=0 after N+1, busy_vec cleared. With REGBANK_WB_BYPASS_EN, a separate case: commit x3=0x55 with rs2addr=3 → fwd2_valid=1, fwd2_data=0x55, rs2_busy=0.
